keypad_scanner: RTL

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner -- 4x4 matrix keypad scanner with debounced press/release.
//
// Drives one active-low column strobe at a time, watches the active-low row
// lines and, once a single-row press has been stable for DEBOUNCE_CYCLES,
// reports it as one-hot row/column vectors with a one-cycle key_valid pulse.
// key_held stays high until the release has been stable for DEBOUNCE_CYCLES.
//
// Build option:
//   KEYPAD_SCANNER_SYNC_EN  defined   : rows pass through a two-flop synchronizer
//                           undefined : rows are registered once
//
// Parameters:
//   SCAN_CYCLES      cycles each column is driven while scanning (>= 4)
//   DEBOUNCE_CYCLES  consecutive stable cycles to accept a press or release (>= 2)
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   rows       raw row lines, active-low, asynchronous to clk
//   col_drive  column strobes, active-low, exactly one bit low
//   row_keys   one-hot row of the last accepted key
//   col_keys   one-hot column of the last accepted key
//   key_valid  one-cycle pulse on press acceptance
//   key_held   high from press acceptance until release is debounced
//
// state    | meaning
// ---------+---------------------------------------------------------------
// SCAN     | rotate the low column every SCAN_CYCLES, look for one low row
// DEBOUNCE | column held, count cycles the captured row pattern stays put
// PRESSED  | key accepted, wait for all rows to go high
// RELEASE  | count all-high cycles; any low row goes back to PRESSED

module keypad_scanner #(
   parameter int SCAN_CYCLES     = 1000,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] rows,
   output logic [3:0] col_drive,
   output logic [3:0] row_keys,
   output logic [3:0] col_keys,
   output logic       key_valid,
   output logic       key_held
);

   localparam int MAX_CYCLES = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
   localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_PRESSED  = 2'd2,
      ST_RELEASE  = 2'd3
   } state_t;

   logic [3:0] rows_s;

`ifdef KEYPAD_SCANNER_SYNC_EN
   logic [3:0] rows_meta;

   always_ff @(posedge clk) begin
      if (!reset) begin
         rows_meta <= 4'b1111;
         rows_s    <= 4'b1111;
      end else begin
         rows_meta <= rows;
         rows_s    <= rows_meta;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (!reset) begin
         rows_s <= 4'b1111;
      end else begin
         rows_s <= rows;
      end
   end
`endif

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [3:0]       pattern, pattern_n;
   logic [3:0]       col_n, row_keys_n, col_keys_n;
   logic             key_valid_n, key_held_n;
   logic [3:0]       col_next;

   // Column after the current one: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
   assign col_next = {col_drive[2:0], col_drive[3]};

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ST_SCAN;
         cnt       <= '0;
         pattern   <= 4'b1111;
         col_drive <= 4'b1110;
         row_keys  <= 4'b0000;
         col_keys  <= 4'b0000;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         pattern   <= pattern_n;
         col_drive <= col_n;
         row_keys  <= row_keys_n;
         col_keys  <= col_keys_n;
         key_valid <= key_valid_n;
         key_held  <= key_held_n;
      end
   end

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      pattern_n   = pattern;
      col_n       = col_drive;
      row_keys_n  = row_keys;
      col_keys_n  = col_keys;
      key_valid_n = 1'b0;
      key_held_n  = key_held;

      case (state)
         ST_SCAN: begin
            if (cnt == SCAN_LAST) begin
               cnt_n = '0;
               // Rows are only trusted at the end of the dwell, after the
               // synchronizer has caught up with the column change.
               if ($onehot(~rows_s)) begin
                  pattern_n = rows_s;
                  state_n   = ST_DEBOUNCE;
               end else begin
                  col_n = col_next;
               end
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         ST_DEBOUNCE: begin
            if (rows_s != pattern) begin
               state_n = ST_SCAN;
               cnt_n   = '0;
            end else if (cnt == DEB_LAST) begin
               state_n     = ST_PRESSED;
               cnt_n       = '0;
               row_keys_n  = ~pattern;
               col_keys_n  = ~col_drive;
               key_valid_n = 1'b1;
               key_held_n  = 1'b1;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         ST_PRESSED: begin
            if (rows_s == 4'b1111) begin
               state_n = ST_RELEASE;
               cnt_n   = '0;
            end
         end
         ST_RELEASE: begin
            if (rows_s != 4'b1111) begin
               state_n = ST_PRESSED;
               cnt_n   = '0;
            end else if (cnt == DEB_LAST) begin
               state_n    = ST_SCAN;
               cnt_n      = '0;
               key_held_n = 1'b0;
               col_n      = col_next;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_n = ST_SCAN;
            cnt_n   = '0;
         end
      endcase
   end

endmodule
